// File: rtl/uart_cmd_parser_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_parser_if
//   Bundles the byte-stream input, the held-frame handshake, the payload read
//   port and the error pulses of the UART command parser.
//
//   Signals (directions as seen by the parser, i.e. the slave modport):
//     i_Rx_DV        in   1-cycle strobe, i_Rx_Byte valid
//     i_Rx_Byte      in   received byte
//     o_Cmd_Valid    out  frame held, waiting for ack
//     i_Cmd_Ack      in   consumer accepts held frame
//     o_Cmd_Code     out  CMD byte of held frame
//     o_Cmd_Len      out  LEN of held frame
//     i_Rd_Addr      in   payload read index
//     o_Rd_Data      out  payload[i_Rd_Addr] (combinational)
//     o_Err_Chk      out  pulse: checksum mismatch
//     o_Err_Len      out  pulse: LEN too large
//     o_Err_Timeout  out  pulse: inter-byte timeout
//     o_Overrun      out  pulse: byte dropped while frame pending
//
//   master: byte source / command consumer side.  slave: the parser.
// ----------------------------------------------------------------------------
interface uart_cmd_parser_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = $clog2(MAX_LEN);

    logic          i_Rx_DV;
    logic [7:0]    i_Rx_Byte;
    logic          o_Cmd_Valid;
    logic          i_Cmd_Ack;
    logic [7:0]    o_Cmd_Code;
    logic [7:0]    o_Cmd_Len;
    logic [AW-1:0] i_Rd_Addr;
    logic [7:0]    o_Rd_Data;
    logic          o_Err_Chk;
    logic          o_Err_Len;
    logic          o_Err_Timeout;
    logic          o_Overrun;

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Cmd_Ack, i_Rd_Addr,
        output o_Cmd_Valid, o_Cmd_Code, o_Cmd_Len, o_Rd_Data,
        output o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Overrun
    );

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Cmd_Ack, i_Rd_Addr,
        input  o_Cmd_Valid, o_Cmd_Code, o_Cmd_Len, o_Rd_Data,
        input  o_Err_Chk, o_Err_Len, o_Err_Timeout, o_Overrun
    );
endinterface

// File: rtl/uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// uart_cmd_parser
//   Turns the UART receiver byte stream into validated command frames:
//     SYNC, CMD, LEN, LEN payload bytes, CHK   (CHK = XOR of CMD, LEN, payload)
//   A good frame is held (o_Cmd_Valid) until i_Cmd_Ack; its payload can be
//   read through i_Rd_Addr/o_Rd_Data.  Bad, oversize or stalled frames are
//   dropped with a one-cycle error pulse.
//
//   Ports:
//     i_Clock   system clock
//     i_Rst_n   synchronous reset, active low
//     bus       uart_cmd_parser_if.slave (byte input, handshake, read port,
//               error pulses)
//
//   Parameters: SYNC_BYTE frame marker, MAX_LEN payload buffer depth (>= 2),
//   TIMEOUT_CLKS max clocks between consecutive bytes inside a frame.
// ----------------------------------------------------------------------------
module uart_cmd_parser #(
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 5400
) (
    input  logic             i_Clock,
    input  logic             i_Rst_n,
    uart_cmd_parser_if.slave bus
);
    localparam int              AW        = $clog2(MAX_LEN);
    localparam int              TW        = $clog2(TIMEOUT_CLKS);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_PAYLOAD,
        S_CHECK,
        S_PENDING
    } state_t;

    state_t        state_q, state_d;

    logic [7:0]    chk_q,  chk_d;
    logic [7:0]    code_q, code_d;
    logic [7:0]    len_q,  len_d;
    logic [AW-1:0] idx_q,  idx_d;
    logic [TW-1:0] tmr_q,  tmr_d;
    logic [7:0]    buf_q [MAX_LEN];

    logic          valid_q,   valid_d;
    logic          err_chk_q, err_chk_d;
    logic          err_len_q, err_len_d;
    logic          err_tmo_q, err_tmo_d;
    logic          ovr_q,     ovr_d;

    logic          rx_dv;
    logic [7:0]    rx_byte;
    logic          counting;
    logic          tmo_hit;
    logic          last_pay;
    logic [7:0]    rd_addr_ext;

    assign rx_dv   = bus.i_Rx_DV;
    assign rx_byte = bus.i_Rx_Byte;

    // The inter-byte timer only runs while a frame is partially received.
    assign counting = (state_q == S_CMD) || (state_q == S_LEN) ||
                      (state_q == S_PAYLOAD) || (state_q == S_CHECK);

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign tmo_hit  = counting && !rx_dv && (tmr_q == TMO_LAST);

    assign last_pay = ({{(8-AW){1'b0}}, idx_q} == (len_q - 8'd1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_dv && rx_byte == SYNC_BYTE) state_d = S_CMD;
            end
            S_CMD: begin
                if (rx_dv) state_d = S_LEN;
            end
            S_LEN: begin
                if (rx_dv) begin
                    if (rx_byte > MAX_LEN_B)  state_d = S_IDLE;
                    else if (rx_byte == 8'd0) state_d = S_CHECK;
                    else                      state_d = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (rx_dv && last_pay) state_d = S_CHECK;
            end
            S_CHECK: begin
                if (rx_dv) state_d = (rx_byte == chk_q) ? S_PENDING : S_IDLE;
            end
            S_PENDING: begin
                // A byte landing together with the ack is still dropped.
                if (bus.i_Cmd_Ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (tmo_hit) state_d = S_IDLE;
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        chk_d     = chk_q;
        code_d    = code_q;
        len_d     = len_q;
        idx_d     = idx_q;
        tmr_d     = '0;
        err_chk_d = 1'b0;
        err_len_d = 1'b0;
        err_tmo_d = tmo_hit;
        ovr_d     = 1'b0;
        valid_d   = (state_d == S_PENDING);

        if (counting && !rx_dv && !tmo_hit) tmr_d = tmr_q + TW'(1);

        case (state_q)
            S_CMD: begin
                if (rx_dv) begin
                    code_d = rx_byte;
                    chk_d  = rx_byte;
                end
            end
            S_LEN: begin
                if (rx_dv) begin
                    chk_d = chk_q ^ rx_byte;
                    idx_d = '0;
                    // Only in-range lengths reach o_Cmd_Len.
                    if (rx_byte > MAX_LEN_B) err_len_d = 1'b1;
                    else                     len_d     = rx_byte;
                end
            end
            S_PAYLOAD: begin
                if (rx_dv) begin
                    chk_d = chk_q ^ rx_byte;
                    idx_d = idx_q + AW'(1);
                end
            end
            S_CHECK: begin
                if (rx_dv && rx_byte != chk_q) err_chk_d = 1'b1;
            end
            S_PENDING: begin
                ovr_d = rx_dv;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            chk_q     <= '0;
            code_q    <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            tmr_q     <= '0;
            valid_q   <= 1'b0;
            err_chk_q <= 1'b0;
            err_len_q <= 1'b0;
            err_tmo_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            chk_q     <= chk_d;
            code_q    <= code_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            tmr_q     <= tmr_d;
            valid_q   <= valid_d;
            err_chk_q <= err_chk_d;
            err_len_q <= err_len_d;
            err_tmo_q <= err_tmo_d;
            ovr_q     <= ovr_d;
        end
    end

    // Payload storage needs no reset: reads are gated by len_q, which is.
    always_ff @(posedge i_Clock) begin
        if (state_q == S_PAYLOAD && rx_dv) buf_q[idx_q] <= rx_byte;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rd_addr_ext = {{(8-AW){1'b0}}, bus.i_Rd_Addr};

    assign bus.o_Cmd_Valid   = valid_q;
    assign bus.o_Cmd_Code    = code_q;
    assign bus.o_Cmd_Len     = len_q;
    assign bus.o_Rd_Data     = (rd_addr_ext < len_q) ? buf_q[bus.i_Rd_Addr] : 8'h00;
    assign bus.o_Err_Chk     = err_chk_q;
    assign bus.o_Err_Len     = err_len_q;
    assign bus.o_Err_Timeout = err_tmo_q;
    assign bus.o_Overrun     = ovr_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_parser
//   Self-checking bench for uart_cmd_parser.  A frame-level reference model
//   (byte position within the frame, stored payload, checksum recomputed from
//   the stored frame, timestamp of the last byte) predicts every output each
//   cycle.  Directed scenarios plus a randomized frame soak.
// ----------------------------------------------------------------------------
module tb_uart_cmd_parser;
    localparam int         T      = 5400;
    localparam int         MAXL   = 16;
    localparam bit [7:0]   SYNC   = 8'hA5;
    localparam bit [7:0]   MAXL_B = 8'd16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_cmd_parser_if #(.MAX_LEN(MAXL)) bus ();

    uart_cmd_parser #(
        .SYNC_BYTE    (SYNC),
        .MAX_LEN      (MAXL),
        .TIMEOUT_CLKS (T)
    ) dut (
        .i_Clock (clk),
        .i_Rst_n (rst_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit       dv;
        bit [7:0] b;
        bit       ack;
        bit       rn;
    } stim_t;
    stim_t stim[$];

    // ---------------- reference model ----------------
    int       m_pos  = -1;   // -1: hunting SYNC; else bytes seen after SYNC
    bit [7:0] m_cmd, m_len;
    bit [7:0] m_pay [MAXL];
    bit       m_pend = 1'b0;
    int       m_cyc  = 0;
    int       m_last = 0;
    bit       e_chk, e_len, e_tmo, e_ovr;

    function automatic bit [7:0] frame_xor();
        bit [7:0] x = m_cmd ^ m_len;
        for (int i = 0; i < int'(m_len); i++) x ^= m_pay[i];
        return x;
    endfunction

    task automatic model_step(input bit dv, input bit [7:0] b, input bit ack, input bit rn);
        m_cyc++;
        {e_chk, e_len, e_tmo, e_ovr} = 4'b0;
        if (!rn) begin
            m_pos  = -1;
            m_pend = 1'b0;
        end else if (m_pend) begin
            if (dv)  e_ovr  = 1'b1;
            if (ack) m_pend = 1'b0;
        end else if (m_pos < 0) begin
            if (dv && b == SYNC) begin
                m_pos  = 0;
                m_last = m_cyc;
            end
        end else if (dv) begin
            m_last = m_cyc;
            if (m_pos == 0) begin
                m_cmd = b;
                m_pos = 1;
            end else if (m_pos == 1) begin
                if (b > MAXL_B) begin
                    e_len = 1'b1;
                    m_pos = -1;
                end else begin
                    m_len = b;
                    m_pos = 2;
                end
            end else if (m_pos < int'(m_len) + 2) begin
                m_pay[m_pos-2] = b;
                m_pos++;
            end else begin
                if (b == frame_xor()) m_pend = 1'b1;
                else                  e_chk  = 1'b1;
                m_pos = -1;
            end
        end else if (m_cyc - m_last == T) begin
            e_tmo = 1'b1;
            m_pos = -1;
        end
    endtask

    // Held-frame fields are compared only while a frame is expected to be held.
    function automatic bit [28:0] exp_obs();
        bit [7:0] rd = 8'h00;
        if (m_pend && 8'(bus.i_Rd_Addr) < m_len) rd = m_pay[bus.i_Rd_Addr];
        return {m_pend, e_chk, e_len, e_tmo, e_ovr,
                m_pend ? m_cmd : 8'h00, m_pend ? m_len : 8'h00, rd};
    endfunction

    function automatic bit [28:0] dut_obs();
        return {bus.o_Cmd_Valid, bus.o_Err_Chk, bus.o_Err_Len, bus.o_Err_Timeout, bus.o_Overrun,
                m_pend ? bus.o_Cmd_Code : 8'h00, m_pend ? bus.o_Cmd_Len : 8'h00,
                m_pend ? bus.o_Rd_Data : 8'h00};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit dv, input bit [7:0] b, input bit ack, input bit rn);
        @(negedge clk);
        bus.i_Rx_DV    = dv;
        bus.i_Rx_Byte  = b;
        bus.i_Cmd_Ack  = ack;
        bus.i_Rd_Addr  = 4'($urandom_range(0, 15));
        rst_n          = rn;
        model_step(dv, b, ack, rn);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit dv, input bit [7:0] b, input bit ack, input bit rn);
        stim_t s;
        s.dv = dv; s.b = b; s.ack = ack; s.rn = rn;
        stim.push_back(s);
    endtask

    task automatic push_idle(input int n);
        for (int i = 0; i < n; i++) push(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    // Bytes are taken MSB-first from v; gap idle cycles follow each byte.
    task automatic push_bytes(input bit [63:0] v, input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            push(1'b1, v[8*(n-1-i) +: 8], 1'b0, 1'b1);
            push_idle(gap);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(1'b1, SYNC, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({bus.o_Cmd_Valid, bus.o_Cmd_Code, bus.o_Cmd_Len, bus.o_Rd_Data, bus.o_Err_Chk,
             bus.o_Err_Len, bus.o_Err_Timeout, bus.o_Overrun} !== 29'd0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b code=%h len=%h rd=%h errs=%b%b%b%b, want all 0",
                     bus.o_Cmd_Valid, bus.o_Cmd_Code, bus.o_Cmd_Len, bus.o_Rd_Data, bus.o_Err_Chk,
                     bus.o_Err_Len, bus.o_Err_Timeout, bus.o_Overrun);
        end
    endtask

    task automatic test_good_frame();
        stim.delete();
        push_bytes(64'hA5_10_02_11_22_21, 6, 1);
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL good_frame step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        bus.i_Rd_Addr = 4'd0; #1;
        checks++;
        if (bus.o_Rd_Data !== 8'h11 || bus.o_Cmd_Code !== 8'h10 || bus.o_Cmd_Len !== 8'h02 || bus.o_Cmd_Valid !== 1'b1) begin
            failures++;
            $display("FAIL good_frame_fields: got v=%b code=%h len=%h rd0=%h want 1 10 02 11",
                     bus.o_Cmd_Valid, bus.o_Cmd_Code, bus.o_Cmd_Len, bus.o_Rd_Data);
        end
        bus.i_Rd_Addr = 4'd1; #1;
        checks++;
        if (bus.o_Rd_Data !== 8'h22) begin
            failures++;
            $display("FAIL good_frame_rd1: got %h want 22", bus.o_Rd_Data);
        end
        bus.i_Rd_Addr = 4'd2; #1;
        checks++;
        if (bus.o_Rd_Data !== 8'h00) begin
            failures++;
            $display("FAIL good_frame_rd2: got %h want 00", bus.o_Rd_Data);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (bus.o_Cmd_Valid !== 1'b0 || dut_obs() !== exp_obs()) begin
            failures++;
            $display("FAIL good_frame_ack: valid got %b want 0", bus.o_Cmd_Valid);
        end
    endtask

    task automatic test_bad_chk();
        int pulses = 0;
        stim.delete();
        push_bytes(64'hA5_10_02_11_22_20, 6, 0);
        push_idle(2);
        push_bytes(64'hA5_10_01_33_22, 5, 0);
        push(1'b0, 8'h00, 1'b1, 1'b1);
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            pulses += int'(bus.o_Err_Chk);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL bad_chk step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL bad_chk_pulses: got %0d want 1", pulses);
        end
    endtask

    task automatic test_junk();
        stim.delete();
        push_bytes(64'h00_FF_A5_07_00_07, 6, 0);
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL junk step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        checks++;
        if (bus.o_Cmd_Valid !== 1'b1 || bus.o_Cmd_Code !== 8'h07 || bus.o_Cmd_Len !== 8'h00) begin
            failures++;
            $display("FAIL junk_fields: got v=%b code=%h len=%h want 1 07 00",
                     bus.o_Cmd_Valid, bus.o_Cmd_Code, bus.o_Cmd_Len);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_len_err();
        stim.delete();
        push_bytes(64'hA5_10_11, 3, 0);
        push_bytes(64'hA5_20_01_44_65, 5, 0);
        push(1'b0, 8'h00, 1'b1, 1'b1);
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL len_err step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_timeout();
        int pulses = 0;
        stim.delete();
        push_bytes(64'hA5_10_02_11, 4, 0);
        push_idle(T + 5);
        // Boundary: the byte on the expiry cycle is accepted.
        push_bytes(64'hA5_10_01, 3, 0);
        push_idle(T - 1);
        push_bytes(64'h55_44, 2, 0);
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            pulses += int'(bus.o_Err_Timeout);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL timeout step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        checks++;
        if (pulses != 1 || bus.o_Cmd_Valid !== 1'b1) begin
            failures++;
            $display("FAIL timeout_count: got pulses=%0d valid=%b want 1 1", pulses, bus.o_Cmd_Valid);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b1);
    endtask

    task automatic test_overrun();
        stim.delete();
        push_bytes(64'hA5_10_02_11_22_21, 6, 0);
        push(1'b1, SYNC, 1'b0, 1'b1);
        push_idle(1);
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL overrun step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        bus.i_Rd_Addr = 4'd1; #1;
        checks++;
        if (bus.o_Cmd_Code !== 8'h10 || bus.o_Cmd_Len !== 8'h02 || bus.o_Rd_Data !== 8'h22 || bus.o_Cmd_Valid !== 1'b1) begin
            failures++;
            $display("FAIL overrun_hold: got v=%b code=%h len=%h rd1=%h want 1 10 02 22",
                     bus.o_Cmd_Valid, bus.o_Cmd_Code, bus.o_Cmd_Len, bus.o_Rd_Data);
        end
        // Byte and ack together: dropped, flagged, parser back to hunting.
        stim.delete();
        push(1'b1, SYNC, 1'b1, 1'b1);
        push_bytes(64'h10_00_10, 3, 0);
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL overrun_ack step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_reset_mid();
        stim.delete();
        push_bytes(64'hA5_10, 2, 0);
        push(1'b0, 8'h00, 1'b0, 1'b0);
        push_bytes(64'h02_11_22_21, 4, 0);
        push_bytes(64'hA5_07_00_07, 4, 0);
        push(1'b0, 8'h00, 1'b1, 1'b1);
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL reset_mid step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    task automatic test_random();
        stim.delete();
        for (int f = 0; f < 40; f++) begin
            bit [7:0] fr [$];
            bit [7:0] x;
            int       len  = $urandom_range(0, 18);
            int       slow = ($urandom_range(0, 9) == 0) ? $urandom_range(1, len + 3) : -1;
            fr.push_back(SYNC);
            fr.push_back(8'($urandom));
            fr.push_back(8'(len));
            for (int k = 0; k < len; k++) fr.push_back(8'($urandom));
            x = 8'h00;
            for (int k = 1; k < fr.size(); k++) x ^= fr[k];
            if ($urandom_range(0, 3) == 0) x ^= 8'(1 << $urandom_range(0, 7));
            fr.push_back(x);
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) push(1'b1, 8'($urandom), 1'b0, 1'b1);
            foreach (fr[k]) begin
                if (k == 4 && $urandom_range(0, 14) == 0) push(1'b0, 8'h00, 1'b0, 1'b0);
                push(1'b1, fr[k], 1'b0, 1'b1);
                if (k == slow) push_idle(($urandom_range(0, 1) == 0) ? T - 1 : T);
                else           push_idle($urandom_range(0, 2));
            end
            if ($urandom_range(0, 3) == 0) push(1'b1, 8'($urandom), 1'b0, 1'b1);
            push(1'b0, 8'h00, 1'b0, 1'b1);
            push($urandom_range(0, 1) == 1, 8'($urandom), 1'b1, 1'b1);
            push_idle(1);
        end
        foreach (stim[i]) begin
            drive(stim[i].dv, stim[i].b, stim[i].ack, stim[i].rn);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                failures++;
                $display("FAIL random step %0d: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    initial begin
        bus.i_Rx_DV   = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        bus.i_Cmd_Ack = 1'b0;
        bus.i_Rd_Addr = '0;
        test_reset();
        test_good_frame();
        test_bad_chk();
        test_junk();
        test_len_err();
        test_timeout();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
